// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs TAP reset, then IR/DR scans of 1..32 bits with a divided TCK.
// Optional TAP reset output trst_o enabled by defining JTAG_SCAN_MASTER_TRST_EN.
module jtag_scan_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_ir,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i,
    output logic        busy
`ifdef JTAG_SCAN_MASTER_TRST_EN
    ,
    output logic        trst_o
`endif
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        RESET_SEQ,
        IDLE,
        HDR,
        SHIFT,
        TAIL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                is_ir_q, is_ir_d;
    logic [CNT_W-1:0]    len_m1_q, len_m1_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                tck_hold;
    logic                tick;
    state_t              nxt_state;

`ifdef JTAG_SCAN_MASTER_TRST_EN
    // TAP held in reset for 16 clk after rst; TCK may not run meanwhile
    logic              trst_q;
    logic [CNT_W-1:0]  trst_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trst_q     <= 1'b1;
            trst_cnt_q <= '0;
        end else if (trst_q) begin
            trst_cnt_q <= CNT_W'(trst_cnt_q + CNT_W'(1));
            if (trst_cnt_q == CNT_W'(15)) begin
                trst_q <= 1'b0;
            end
        end
    end

    assign trst_o   = trst_q;
    assign tck_hold = trst_q;
`else
    assign tck_hold = 1'b0;
`endif

    // TMS level required for TCK cycle c of a given state
    function automatic logic tms_of(input state_t s, input logic [CNT_W-1:0] c,
                                    input logic ir, input logic [CNT_W-1:0] lm1);
        case (s)
            RESET_SEQ: return (c < CNT_W'(5));
            HDR:       return ir ? (c < CNT_W'(2)) : (c == CNT_W'(0));
            SHIFT:     return (c == lm1);
            TAIL:      return (c == CNT_W'(0));
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic is_last(input state_t s, input logic [CNT_W-1:0] c,
                                     input logic ir, input logic [CNT_W-1:0] lm1);
        case (s)
            RESET_SEQ: return (c == CNT_W'(5));
            HDR:       return (c == (ir ? CNT_W'(3) : CNT_W'(2)));
            SHIFT:     return (c == lm1);
            TAIL:      return (c == CNT_W'(1));
            default:   return 1'b1;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            RESET_SEQ: return IDLE;
            HDR:       return SHIFT;
            SHIFT:     return TAIL;
            TAIL:      return DONE;
            default:   return IDLE;
        endcase
    endfunction

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign nxt_state = next_of(state_q);

    // Next-state, TCK phase sequencing and output computation
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        tck_d       = tck_q;
        is_ir_d     = is_ir_q;
        len_m1_d    = len_m1_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_ir_d  = cmd_is_ir;
                    len_m1_d = ((cmd_len == 6'd0) || (cmd_len > 6'd32)) ?
                               CNT_W'(31) : CNT_W'(cmd_len - 6'd1);
                    data_d   = cmd_data;
                    cap_d    = '0;
                    state_d  = HDR;
                    cnt_d    = '0;
                    div_d    = '0;
                    tck_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            RESET_SEQ, HDR, SHIFT, TAIL: begin
                if (!((state_q == RESET_SEQ) && tck_hold)) begin
                    if (!tick) begin
                        div_d = DIV_W'(div_q + DIV_W'(1));
                    end else begin
                        div_d = '0;
                        if (!tck_q) begin
                            tck_d = 1'b1;
                            if (state_q == SHIFT) begin
                                cap_d[cnt_q] = tdo_i;
                            end
                        end else begin
                            // Falling TCK edge: advance to the next TCK cycle
                            tck_d = 1'b0;
                            if (is_last(state_q, cnt_q, is_ir_q, len_m1_q)) begin
                                state_d = nxt_state;
                                cnt_d   = '0;
                                if (nxt_state == DONE) begin
                                    rsp_valid_d = 1'b1;
                                    rsp_data_d  = cap_q;
                                end
                            end else begin
                                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = RESET_SEQ;
            end
        endcase

        // TMS/TDI only move when the TCK cycle index moves
        tms_d       = tms_of(state_d, cnt_d, is_ir_d, len_m1_d);
        tdi_d       = (state_d == SHIFT) ? data_d[cnt_d] : 1'b0;
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_SEQ;
            div_q       <= '0;
            cnt_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            is_ir_q     <= 1'b0;
            len_m1_q    <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            is_ir_q     <= is_ir_d;
            len_m1_q    <= len_m1_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign tck_o     = tck_q;
    assign tms_o     = tms_q;
    assign tdi_o     = tdi_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master driving a 5-bit-IR TAP model with IDCODE 0x1E200A6D.
module tb_jtag_scan_master;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [31:0] IDCODE  = 32'h1E200A6D;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_ir = 1'b0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck_o, tms_o, tdi_o;
    logic        tdo_i = 1'b0;
    logic        busy;
`ifdef JTAG_SCAN_MASTER_TRST_EN
    logic        trst_o;
`endif

    jtag_scan_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_is_ir (cmd_is_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tck_o     (tck_o),
        .tms_o     (tms_o),
        .tdi_o     (tdi_o),
        .tdo_i     (tdo_i),
        .busy      (busy)
`ifdef JTAG_SCAN_MASTER_TRST_EN
        ,
        .trst_o    (trst_o)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_rsp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- TAP model ----------------
    int          tap_st = TLR;
    logic [4:0]  tap_ir = 5'd1;
    logic [4:0]  ir_sr = 5'd0;
    logic [31:0] dr_sr = 32'd0;
    int          tck_cnt = 0;
    int          bad_tdi = 0;
    int          bad_width = 0;
    time         t_rise = 0;
    logic        tms_log[$];

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PAUDR;
            PAUDR: return tms ? EX2DR : PAUDR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PAUIR;
            PAUIR: return tms ? EX2IR : PAUIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        tck_cnt++;
        t_rise = $time;
        tms_log.push_back(tms_o);
        if (tap_st != SHIR && tap_st != SHDR && tdi_o !== 1'b0) bad_tdi++;
        case (tap_st)
            TLR:   tap_ir = 5'd1;
            CAPIR: ir_sr = 5'b00001;
            SHIR:  ir_sr = {tdi_o, ir_sr[4:1]};
            UPIR:  tap_ir = ir_sr;
            CAPDR: dr_sr = (tap_ir == 5'd1) ? IDCODE : 32'd0;
            SHDR:  dr_sr = (tap_ir == 5'd1) ? {tdi_o, dr_sr[31:1]} : {31'd0, tdi_o};
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o) begin
        if (!rst && ($time - t_rise != 64'(CLK_DIV * 10))) bad_width++;
        tdo_i = (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          tcks;
        int          tck_start;
        logic [4:0]  ir;
    } exp_t;

    exp_t       q[$];
    logic [4:0] ir_model = 5'd1;

    function automatic logic [63:0] mask64(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // A scan shifts the register's capture value out first, followed by the TDI bits
    task automatic push_expected(input logic ir, input logic [5:0] len, input logic [31:0] data);
        exp_t        e;
        int          el;
        int          w;
        logic [31:0] cap;
        logic [63:0] seq;
        el = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
        if (ir) begin
            w = 5;  cap = 32'h1;
        end else if (ir_model == 5'd1) begin
            w = 32; cap = IDCODE;
        end else begin
            w = 1;  cap = 32'h0;
        end
        seq = ((64'(data) & mask64(el)) << w) | 64'(cap);
        e.data      = 32'(seq & mask64(el));
        e.tcks      = (ir ? 6 : 5) + el;
        e.tck_start = tck_cnt;
        if (ir) ir_model = 5'((seq >> el) & mask64(5));
        e.ir = ir_model;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 data 0x%0h, expected no response", rsp_data);
                end else begin
                    e = q.pop_front();
                    last_rsp_cyc = cyc;
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("tck_count", 64'(tck_cnt - e.tck_start), 64'(e.tcks));
                    check("tap_ir", 64'(tap_ir), 64'(e.ir));
                    check("tap_state_end", 64'(tap_st), 64'(RTI));
                    @(negedge clk);
                    check("ready_after_rsp", 64'(cmd_ready), 64'd1);
                end
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic send(input logic ir, input logic [5:0] len, input logic [31:0] data, input bit hold);
        int budget;
        cmd_valid = 1'b1;
        cmd_is_ir = ir;
        cmd_len   = len;
        cmd_data  = data;
        budget    = 0;
        while (!cmd_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, expected 1", budget);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        push_expected(ir, len, data);
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_is_ir = 1'b0;
            cmd_len   = 6'd8;
            cmd_data  = 32'hFFFF_FFFF;
        end else begin
            cmd_valid = 1'b0;
            cmd_is_ir = 1'($urandom);
            cmd_len   = 6'($urandom);
            cmd_data  = $urandom;
        end
    endtask

    task automatic wait_done();
        int budget = 0;
        @(negedge clk);
        while ((q.size() != 0 || !cmd_ready) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0 || !cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_timeout: %0d responses outstanding, cmd_ready=%0b, expected 0 and 1", q.size(), cmd_ready);
            q.delete();
        end
    endtask

    task automatic check_reset_vals();
        check("rst_tck", 64'(tck_o), 64'd0);
        check("rst_tms", 64'(tms_o), 64'd1);
        check("rst_tdi", 64'(tdi_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
    endtask

    // Called at the negedge where rst is released
    task automatic check_reset_seq();
        int         start;
        int         budget = 0;
        logic [5:0] pat = 6'd0;
`ifdef JTAG_SCAN_MASTER_TRST_EN
        int k = 0;
        start = tck_cnt;
        while (trst_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("trst_len", 64'(k), 64'd16);
        check("tck_before_trst", 64'(tck_cnt - start), 64'd0);
`endif
        tms_log.delete();
        start = tck_cnt;
        while (!cmd_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        for (int i = 0; i < tms_log.size() && i < 6; i++) pat[5-i] = tms_log[i];
        check("rst_seq_tcks", 64'(tck_cnt - start), 64'd6);
        check("rst_seq_tms", 64'(pat), 64'b111110);
        check("rst_seq_busy", 64'(busy), 64'd0);
        check("rst_seq_ready", 64'(cmd_ready), 64'd1);
        check("rst_seq_tap_state", 64'(tap_st), 64'(RTI));
        check("rst_seq_tap_ir", 64'(tap_ir), 64'd1);
        ir_model = 5'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int budget;
        logic        r_ir;
        logic [31:0] r_data;

        repeat (3) @(negedge clk);
        check_reset_vals();
`ifdef JTAG_SCAN_MASTER_TRST_EN
        check("rst_trst", 64'(trst_o), 64'd1);
`endif
        rst = 1'b0;
        check_reset_seq();

        // Directed IR then DR (IDCODE)
        send(1'b1, 6'd5, 32'h1, 1'b0);
        wait_done();
        send(1'b0, 6'd0, 32'h0, 1'b0);
        wait_done();

        // cmd_valid held through a scan: second command only after rsp_valid
        send(1'b0, 6'd12, $urandom, 1'b1);
        send(1'b0, 6'd8, 32'hFFFF_FFFF, 1'b0);
        check("accept_after_rsp", 64'(acc_cyc), 64'(last_rsp_cyc + 1));
        wait_done();

        // Randomized scans
        for (int n = 0; n < 24; n++) begin
            r_ir   = 1'($urandom_range(0, 1));
            r_data = (r_ir && $urandom_range(0, 2) == 0) ? 32'h1 : $urandom;
            send(r_ir, 6'($urandom_range(0, 63)), r_data, 1'b0);
            wait_done();
        end

        // Reset in the middle of shift bit 10 of a DR scan
        st = tck_cnt;
        send(1'b0, 6'd32, $urandom, 1'b0);
        budget = 0;
        while (tck_cnt - st < 13 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        rst = 1'b1;
        #1;
        check_reset_vals();
        q.delete();
        repeat (4) @(negedge clk);
        check("rst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        check_reset_seq();

        send(1'b1, 6'd5, 32'h2, 1'b0);
        wait_done();
        send(1'b0, 6'd9, $urandom, 1'b0);
        wait_done();

        repeat (4) @(negedge clk);
        check("tck_high_width_errors", 64'(bad_width), 64'd0);
        check("tdi_outside_shift", 64'(bad_tdi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
